// File: rtl/dm_pkg.sv
// dm_pkg: shared types and default sizes for the data-memory controller.
package dm_pkg;
  localparam int DM_DW = 16;
  localparam int DM_AW = 8;
  typedef enum logic {CLEAR, RUN} dm_state_t;
  typedef enum logic [1:0] {SEL_ZERO, SEL_RAM, SEL_FWD} dm_sel_t;
endpackage

// File: rtl/dm_sram.sv
// dm_sram: single-port array, synchronous write, registered read that holds between reads.
module dm_sram #(
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/dm_ctrl.sv
// dm_ctrl: data-memory controller with power-on clear, posted write buffer and read forwarding.
module dm_ctrl
  import dm_pkg::*;
#(
  parameter int DW = DM_DW,
  parameter int AW = DM_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] dg_dm_add,
  input  logic          ps_dm_en,
  input  logic          ps_dm_wrt,
  input  logic [DW-1:0] bc_dt,
  output logic [DW-1:0] dm_bc_dt,
  output logic          dm_rd_vld,
  output logic          dm_busy,
  output logic          dm_err
);
  dm_state_t     state, state_n;
  dm_sel_t       sel;
  logic [AW-1:0] cnt, idx, buf_idx, sram_addr;
  logic [DW-1:0] buf_d, fwd_d, sram_wd, sram_q;
  logic          buf_v, clr, acc, inr, rd, wr, drain, sram_we;
  always_comb begin
    clr       = state == CLEAR;
    acc       = !clr && ps_dm_en;
    inr       = dg_dm_add[DW-1:AW] == '0;
    idx       = dg_dm_add[AW-1:0];
    rd        = acc && !ps_dm_wrt && inr;
    wr        = acc && ps_dm_wrt && inr;
    drain     = !clr && buf_v && !rd;
    sram_we   = clr || drain;
    sram_addr = clr ? cnt : rd ? idx : buf_idx;
    sram_wd   = clr ? '0 : buf_d;
    state_n   = (clr && cnt == '1) ? RUN : state;
    dm_busy   = clr;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      cnt       <= '0;
      buf_v     <= 1'b0;
      buf_idx   <= '0;
      buf_d     <= '0;
      fwd_d     <= '0;
      sel       <= SEL_ZERO;
      dm_rd_vld <= 1'b0;
      dm_err    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= clr ? cnt + 1'b1 : cnt;
      dm_rd_vld <= acc && !ps_dm_wrt;
      dm_err    <= acc && !inr;
      if (wr) begin
        buf_v   <= 1'b1;
        buf_idx <= idx;
        buf_d   <= bc_dt;
      end else if (drain) buf_v <= 1'b0;
      if (acc && !ps_dm_wrt) begin
        sel   <= !inr ? SEL_ZERO : (buf_v && buf_idx == idx) ? SEL_FWD : SEL_RAM;
        fwd_d <= buf_d;
      end
    end
  end
  // output select is registered; the array output itself holds between reads
  assign dm_bc_dt = sel == SEL_RAM ? sram_q : sel == SEL_FWD ? fwd_d : '0;
  dm_sram #(.DW(DW), .AW(AW)) u_sram (
    .clk  (clk),
    .we   (sram_we),
    .re   (rd),
    .addr (sram_addr),
    .wdata(sram_wd),
    .rdata(sram_q)
  );
endmodule

// File: tb/tb_dm_ctrl.sv
// tb_dm_ctrl: directed self-checking bench for dm_ctrl.
module tb_dm_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] dg_dm_add = '0;
  logic        ps_dm_en = 1'b0;
  logic        ps_dm_wrt = 1'b0;
  logic [15:0] bc_dt = '0;
  logic [15:0] dm_bc_dt;
  logic        dm_rd_vld, dm_busy, dm_err;
  int          checks = 0;
  int          errors = 0;
  int          n;
  logic        seen;
  dm_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .dg_dm_add(dg_dm_add),
    .ps_dm_en (ps_dm_en),
    .ps_dm_wrt(ps_dm_wrt),
    .bc_dt    (bc_dt),
    .dm_bc_dt (dm_bc_dt),
    .dm_rd_vld(dm_rd_vld),
    .dm_busy  (dm_busy),
    .dm_err   (dm_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic en, input logic wrt, input logic [15:0] add, input logic [15:0] dt);
    ps_dm_en  = en;
    ps_dm_wrt = wrt;
    dg_dm_add = add;
    bc_dt     = dt;
    @(negedge clk);
  endtask
  task automatic clear_wait(output int cnt, output logic pulse);
    cyc(1'b1, 1'b0, 16'h0042, 16'h0);
    cnt   = 1;
    pulse = dm_rd_vld | dm_err;
    while (dm_busy && cnt < 600) begin
      cyc(1'b0, 1'b0, 16'h0, 16'h0);
      cnt++;
      pulse |= dm_rd_vld | dm_err;
    end
  endtask
  initial begin
    rst = 1'b1;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("rst_busy", dm_busy, 1);
    chk("rst_vld", dm_rd_vld, 0);
    chk("rst_err", dm_err, 0);
    chk("rst_data", dm_bc_dt, 0);
    rst = 1'b0;
    clear_wait(n, seen);
    chk("busy_len", n, 256);
    chk("busy_no_pulse", seen, 0);
    // posted write then immediate read is forwarded
    cyc(1, 1, 16'h0010, 16'hBEEF);
    chk("wr_vld", dm_rd_vld, 0);
    chk("wr_err", dm_err, 0);
    cyc(1, 0, 16'h0010, 16'h0);
    chk("fwd_vld", dm_rd_vld, 1);
    chk("fwd_data", dm_bc_dt, 16'hBEEF);
    cyc(0, 0, 0, 0);
    chk("idle_vld", dm_rd_vld, 0);
    chk("hold_data", dm_bc_dt, 16'hBEEF);
    // two writes, drain, then array reads back-to-back
    cyc(1, 1, 16'h0001, 16'h1111);
    cyc(1, 1, 16'h0002, 16'h2222);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 16'h0001, 16'h0);
    chk("rd1_vld", dm_rd_vld, 1);
    chk("rd1_data", dm_bc_dt, 16'h1111);
    cyc(1, 0, 16'h0002, 16'h0);
    chk("rd2_vld", dm_rd_vld, 1);
    chk("rd2_data", dm_bc_dt, 16'h2222);
    cyc(1, 0, 16'h0010, 16'h0);
    chk("rd10_data", dm_bc_dt, 16'hBEEF);
    // forwarded value must win over the stale array word
    cyc(1, 1, 16'h0010, 16'h7777);
    cyc(1, 0, 16'h0010, 16'h0);
    chk("fwd_new", dm_bc_dt, 16'h7777);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 16'h0010, 16'h0);
    chk("drained_new", dm_bc_dt, 16'h7777);
    // out-of-range accesses
    cyc(1, 0, 16'h0100, 16'h0);
    chk("oor_rd_data", dm_bc_dt, 0);
    chk("oor_rd_vld", dm_rd_vld, 1);
    chk("oor_rd_err", dm_err, 1);
    cyc(0, 0, 0, 0);
    chk("err_pulse_end", dm_err, 0);
    cyc(1, 1, 16'hFF00, 16'h5A5A);
    chk("oor_wr_err", dm_err, 1);
    chk("oor_wr_vld", dm_rd_vld, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 16'h0000, 16'h0);
    chk("rd0_data", dm_bc_dt, 0);
    chk("rd0_err", dm_err, 0);
    // unwritten word and back-to-back reads
    cyc(1, 0, 16'h00FF, 16'h0);
    chk("rdff_data", dm_bc_dt, 0);
    cyc(1, 0, 16'h0003, 16'h0);
    chk("b2b_vld1", dm_rd_vld, 1);
    cyc(1, 0, 16'h0004, 16'h0);
    chk("b2b_vld2", dm_rd_vld, 1);
    chk("b2b_data", dm_bc_dt, 0);
    // reset discards the buffered write and re-zeroes the array
    cyc(1, 1, 16'h0020, 16'hCAFE);
    rst = 1'b1;
    cyc(0, 0, 0, 0);
    chk("rst2_busy", dm_busy, 1);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0);
    rst = 1'b1;
    cyc(0, 0, 0, 0);
    rst = 1'b0;
    clear_wait(n, seen);
    chk("busy_len_restart", n, 256);
    cyc(1, 0, 16'h0020, 16'h0);
    chk("rd20_data", dm_bc_dt, 0);
    chk("rd20_vld", dm_rd_vld, 1);
    cyc(1, 0, 16'h0001, 16'h0);
    chk("rd1_cleared", dm_bc_dt, 0);
    cyc(0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dm_ctrl.md
DM_CTRL -- requirements
Module: dm_ctrl

Interface
REQ-001 SHALL have parameter DW, default 16: data and address width.
REQ-002 SHALL have parameter AW, default 8: array index width; depth 2^AW = 256 words.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk  in  1: rising-edge clock for all state.
REQ-005 SHALL have port rst  in  1: synchronous reset, active-high.
REQ-006 SHALL have port dg_dm_add  in  DW: data-memory address driven by the DAG.
REQ-007 SHALL have port ps_dm_en  in  1: access request, one per cycle.
REQ-008 SHALL have port ps_dm_wrt  in  1: 1 = write, 0 = read; valid only with ps_dm_en.
REQ-009 SHALL have port bc_dt  in  DW: write data from the data bus.
REQ-010 SHALL have port dm_bc_dt  out  DW: registered read data to the bus.
REQ-011 SHALL have port dm_rd_vld  out  1: one-cycle pulse marking dm_bc_dt as new read data.
REQ-012 SHALL have port dm_busy  out  1: high while clearing; requests are ignored while high.
REQ-013 SHALL have port dm_err  out  1: one-cycle pulse, registered, for an out-of-range request.

Function
REQ-014 SHALL implement states CLEAR and RUN; reset enters CLEAR with clear counter = 0.
REQ-015 In CLEAR, SHALL write 0 to array[counter] each cycle, increment counter, assert dm_busy, and ignore ps_dm_en.
REQ-016 SHALL go to RUN on the cycle after counter = 2^AW-1 is written; dm_busy is low from that cycle.
REQ-017 Address in range iff dg_dm_add[DW-1:AW] = 0; index = dg_dm_add[AW-1:0].
REQ-018 SHALL have a 1-entry posted write buffer (valid, index, data); the array is single-port with one access per cycle.
REQ-019 Read request (RUN, en=1, wrt=0, in range) at cycle N: SHALL use the array port for the read; the buffer is held; dm_bc_dt and dm_rd_vld=1 appear at N+1.
REQ-020 Read forwarding: if the buffer is valid and its index matches, dm_bc_dt at N+1 SHALL equal the buffer data, not the array data.
REQ-021 Write request (in range) with buffer valid: SHALL write the buffer to the array in the same cycle and load the new request into the buffer.
REQ-022 Write request (in range) with buffer empty: SHALL only load the buffer; the array stays idle.
REQ-023 Idle cycle (no accepted request) in RUN with buffer valid: SHALL drain the buffer to the array and clear valid.
REQ-024 Out-of-range read: dm_bc_dt = 0 and dm_rd_vld = 1 at N+1, dm_err = 1 at N+1, no array access.
REQ-025 Out-of-range write: request dropped, buffer untouched (drain rules still apply), dm_err = 1 at N+1.
REQ-026 dm_bc_dt SHALL hold its value between reads; dm_rd_vld and dm_err are 0 except for their pulse cycle.
REQ-027 ps_dm_wrt SHALL be don't-care when ps_dm_en = 0; a request during CLEAR produces no pulse on any output.

Reset
REQ-028 Reset SHALL set dm_bc_dt = 0, dm_rd_vld = 0, dm_err = 0, dm_busy = 1, buffer valid = 0, state CLEAR, counter 0.
REQ-029 Reset mid-RUN SHALL discard a pending buffered write; the array is then re-zeroed by CLEAR.
REQ-030 Reset mid-CLEAR SHALL restart clearing at index 0.

Structure
REQ-031 Package dm_pkg SHALL hold the state enum (CLEAR, RUN) and the default DW/AW constants.
REQ-032 SHALL instantiate one sub-module, dm_sram: single-port array with 1-cycle registered read and synchronous write enable.
REQ-033 Array mux priority SHALL be: CLEAR write > read request > buffer write (write request or drain).

Verification
REQ-034 Reset, then count cycles -> dm_busy high for exactly 256 cycles; a read of 0x0042 during busy gives no dm_rd_vld.
REQ-035 Write 0x0010 <- 0xBEEF, then read 0x0010 on the next cycle -> dm_bc_dt = 0xBEEF, forwarded, with dm_rd_vld one cycle after the read.
REQ-036 Write 0x0001 <- 0x1111, write 0x0002 <- 0x2222, idle, then read 0x0001 and 0x0002 -> 0x1111 and 0x2222 from the array.
REQ-037 Read 0x0100 -> dm_bc_dt = 0, dm_rd_vld = 1, dm_err = 1; write 0xFF00 <- 0x5A5A -> dm_err = 1, and a later read of 0x0000 returns 0.
REQ-038 Write 0x0020 <- 0xCAFE, reset next cycle, wait for CLEAR to finish, read 0x0020 -> 0x0000.
REQ-039 Read of unwritten 0x00FF after CLEAR -> 0x0000; back-to-back reads of 0x0003 and 0x0004 -> dm_rd_vld high for two consecutive cycles.
